// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_DIV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier and restoring divider sharing one hi/lo register pair.
// One iteration per cycle; done/result/flag are valid in the cycle of the final iteration.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int SHW = $clog2(WIDTH);

  logic             busy;
  logic             is_div;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi, lo, opb;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   mul_sum, shifted, trial;
  logic             ge;

  // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0].
  // Divide: {hi,lo} shifts left, quotient bits enter at lo[0]; a zero
  // divisor always "fits", which yields an all-ones quotient for free.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opb});
    trial   = shifted - {1'b0, opb};
    if (is_div) begin
      hi_n = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
    done   = busy && (cnt == SHW'(WIDTH - 1));
    result = lo_n;
    flag   = is_div ? (opb == '0) : (|hi_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_div <= (op == ALU_DIV);
      cnt    <= '0;
      hi     <= '0;
      lo     <= a;
      opb    <= b;
    end else if (busy) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + SHW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus iterative MUL/DIV, registered results.
// Optional macro ALU_SIGNED_OVF_EN adds the registered signed Overflow output.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Code,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Carry,
  output logic             isZero,
`ifdef ALU_SIGNED_OVF_EN
  output logic             Overflow,
`endif
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  // Handshake: an op is accepted on a rising edge where In_Valid & In_Ready;
  // a result is consumed on a rising edge where Out_Valid & Out_Ready, and
  // ALU_Out/flags hold steady from Out_Valid rising until that edge.

  state_t           state;
  logic [WIDTH:0]   sum, diff, shl;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             is_iter, it_start, it_done, it_flag;
  logic [WIDTH-1:0] it_result;

  assign dbg_state = state;
  assign is_iter   = (ALU_Code == ALU_MUL) || (ALU_Code == ALU_DIV);
  assign it_start  = (state == IDLE) && In_Valid && is_iter;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    shl      = {1'b0, A} << B[SHW-1:0];
    sc_res   = '0;
    sc_carry = 1'b0;
    case (ALU_Code)
      ALU_ADD: begin sc_res = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  end
      ALU_SUB: begin sc_res = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; end
      ALU_AND: sc_res = A & B;
      ALU_OR:  sc_res = A | B;
      ALU_XOR: sc_res = A ^ B;
      ALU_SHL: begin sc_res = shl[WIDTH-1:0];  sc_carry = shl[WIDTH];  end
      default: ;
    endcase
  end

`ifdef ALU_SIGNED_OVF_EN
  logic sc_ovf;
  always_comb begin
    sc_ovf = 1'b0;
    if (ALU_Code == ALU_ADD)
      sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (ALU_Code == ALU_SUB)
      sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end
`endif

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (it_start),
    .op     (ALU_Code),
    .a      (A),
    .b      (B),
    .done   (it_done),
    .result (it_result),
    .flag   (it_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      ALU_Out   <= '0;
      Carry     <= 1'b0;
      isZero    <= 1'b0;
`ifdef ALU_SIGNED_OVF_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (In_Valid) begin
          In_Ready <= 1'b0;
          if (is_iter) begin
            state <= BUSY;
          end else begin
            state     <= DONE;
            Out_Valid <= 1'b1;
            ALU_Out   <= sc_res;
            Carry     <= sc_carry;
            isZero    <= (sc_res == '0);
`ifdef ALU_SIGNED_OVF_EN
            Overflow  <= sc_ovf;
`endif
          end
        end
        BUSY: if (it_done) begin
          state     <= DONE;
          Out_Valid <= 1'b1;
          ALU_Out   <= it_result;
          Carry     <= it_flag;
          isZero    <= (it_result == '0);
`ifdef ALU_SIGNED_OVF_EN
          Overflow  <= 1'b0;
`endif
        end
        DONE: if (Out_Ready) begin
          state     <= IDLE;
          Out_Valid <= 1'b0;
          In_Ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, In_Valid, Out_Ready;
  logic         In_Ready, Out_Valid, Carry, isZero;
  logic [W-1:0] A, B, ALU_Out;
  logic [2:0]   ALU_Code;
  logic [1:0]   dbg_state;
`ifdef ALU_SIGNED_OVF_EN
  logic         Overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] a, b, exp;
    logic         c;
    int           lat;
  } vec_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .ALU_Code  (ALU_Code),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .ALU_Out   (ALU_Out),
    .Carry     (Carry),
    .isZero    (isZero),
`ifdef ALU_SIGNED_OVF_EN
    .Overflow  (Overflow),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with the DUT idle. Returns the number of
  // edges from the accept edge (counted as 1) until Out_Valid is seen.
  task automatic issue(input logic [2:0] code, input logic [W-1:0] a, b,
                       output int lat, output logic ready_seen);
    In_Valid = 1'b1; ALU_Code = code; A = a; B = b;
    @(posedge clk); #1;
    In_Valid = 1'b0;
    A = W'($urandom); B = W'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!Out_Valid && lat < 100) begin
      if (In_Ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    Out_Ready = 1'b1;
    @(posedge clk); #1;
    Out_Ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
    A = '0; B = '0; ALU_Code = ALU_ADD;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_tests++;
    if ({In_Ready, Out_Valid, ALU_Out, Carry, isZero} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b out=%h c=%b z=%b, want rdy=1 vld=0 out=0000 c=0 z=0",
               In_Ready, Out_Valid, ALU_Out, Carry, isZero);
    end
    n_tests++;
    if (dbg_state !== 2'(IDLE)) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_vectors(input string name, input vec_t vs[$]);
    int lat;
    logic rs;
    foreach (vs[i]) begin
      issue(vs[i].code, vs[i].a, vs[i].b, lat, rs);
      n_tests++;
      if (ALU_Out !== vs[i].exp) begin
        n_fail++;
        $display("FAIL %s[%0d] out: got %h want %h", name, i, ALU_Out, vs[i].exp);
      end
      n_tests++;
      if ({Carry, isZero} !== {vs[i].c, vs[i].exp == '0}) begin
        n_fail++;
        $display("FAIL %s[%0d] flags: got c=%b z=%b want c=%b z=%b",
                 name, i, Carry, isZero, vs[i].c, vs[i].exp == '0);
      end
      n_tests++;
      if (lat != vs[i].lat || rs !== 1'b0) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d (rdy_seen=%b) want %0d (rdy_seen=0)",
                 name, i, lat, rs, vs[i].lat);
      end
      consume();
    end
  endtask

  task automatic test_single_cycle();
    vec_t vs[$];
    vs.push_back('{ALU_ADD, 16'h0002, 16'h0005, 16'h0007, 1'b0, 1});
    vs.push_back('{ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1});
    vs.push_back('{ALU_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1});
    vs.push_back('{ALU_SUB, 16'h0009, 16'h0004, 16'h0005, 1'b0, 1});
    vs.push_back('{ALU_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1});
    vs.push_back('{ALU_OR,  16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1});
    vs.push_back('{ALU_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1});
    vs.push_back('{ALU_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1});
    vs.push_back('{ALU_SHL, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1});
    vs.push_back('{ALU_SHL, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1});
    test_vectors("single", vs);
  endtask

  task automatic test_iterative();
    vec_t vs[$];
    vs.push_back('{ALU_MUL, 16'h0007, 16'h0006, 16'h002A, 1'b0, 17});
    vs.push_back('{ALU_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17});
    vs.push_back('{ALU_MUL, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 17});
    vs.push_back('{ALU_DIV, 16'd100,  16'd7,    16'h000E, 1'b0, 17});
    vs.push_back('{ALU_DIV, 16'd5,    16'd0,    16'hFFFF, 1'b1, 17});
    vs.push_back('{ALU_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17});
    vs.push_back('{ALU_DIV, 16'd3,    16'd9,    16'h0000, 1'b0, 17});
    test_vectors("iter", vs);
  endtask

`ifdef ALU_SIGNED_OVF_EN
  task automatic test_overflow();
    logic [2:0]   codes[3] = '{ALU_ADD, ALU_SUB, ALU_SUB};
    logic [W-1:0] as[3]    = '{16'h7FFF, 16'h8000, 16'h0003};
    logic [W-1:0] bs[3]    = '{16'h0001, 16'h0001, 16'h0005};
    logic         ov[3]    = '{1'b1, 1'b1, 1'b0};
    int lat;
    logic rs;
    for (int i = 0; i < 3; i++) begin
      issue(codes[i], as[i], bs[i], lat, rs);
      n_tests++;
      if (Overflow !== ov[i]) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got %b want %b", i, Overflow, ov[i]);
      end
      consume();
    end
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    logic rs;
    issue(ALU_ADD, 16'd9, 16'd9, lat, rs);
    for (int i = 0; i < 5; i++) begin
      In_Valid = 1'b1; ALU_Code = ALU_SUB; A = 16'd1; B = 16'd1;
      @(posedge clk); #1;
      n_tests++;
      if ({Out_Valid, In_Ready, ALU_Out, Carry, isZero} !== {1'b1, 1'b0, 16'd18, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got vld=%b rdy=%b out=%h c=%b z=%b want vld=1 rdy=0 out=0012 c=0 z=0",
                 i, Out_Valid, In_Ready, ALU_Out, Carry, isZero);
      end
    end
    In_Valid = 1'b0;
    consume();
    n_tests++;
    if ({Out_Valid, In_Ready, dbg_state} !== {1'b0, 1'b1, 2'(IDLE)}) begin
      n_fail++;
      $display("FAIL release: got vld=%b rdy=%b st=%0d want vld=0 rdy=1 st=0",
               Out_Valid, In_Ready, dbg_state);
    end
    @(posedge clk); #1;
    n_tests++;
    if (Out_Valid !== 1'b0 || ALU_Out !== 16'd18) begin
      n_fail++;
      $display("FAIL ignored_op: got vld=%b out=%h want vld=0 out=0012", Out_Valid, ALU_Out);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic rs;
    int rises = 0;
    In_Valid = 1'b1; ALU_Code = ALU_MUL; A = 16'd7; B = 16'd6;
    @(posedge clk); #1;
    In_Valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({Out_Valid, ALU_Out, Carry, isZero} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got vld=%b out=%h c=%b z=%b want all zero",
               Out_Valid, ALU_Out, Carry, isZero);
    end
    reset = 1'b0;
    n_tests++;
    if (In_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", In_Ready);
    end
    repeat (30) begin
      @(posedge clk); #1;
      if (Out_Valid) rises++;
    end
    n_tests++;
    if (rises != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abandon: Out_Valid high %0d cycles, want 0", rises);
    end
    issue(ALU_ADD, 16'd1, 16'd1, lat, rs);
    n_tests++;
    if (ALU_Out !== 16'd2 || lat != 1) begin
      n_fail++;
      $display("FAIL after_reset_add: got out=%h lat=%0d want out=0002 lat=1", ALU_Out, lat);
    end
    consume();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
`ifdef ALU_SIGNED_OVF_EN
    test_overflow();
`endif
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
